// File: rtl/data_mem_access_unit.sv
// Load/store unit for a word-wide single-port synchronous data RAM.
// Sub-word stores run as read-modify-write because the RAM has no byte enables.
module data_mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              DMWR,
  input  logic [2:0]        DMCtrl,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              misaligned,
  output logic              illegal,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_wr;
  logic [2:0]        r_ctrl;
  logic [ADDR_W+1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_mis;
  logic              r_ill;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem_wdata;

  logic              w_accept;
  logic              w_ill;
  logic              w_mis;
  logic [1:0]        w_size;
  logic [1:0]        w_size_q;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_merged;

  // Store encodings differ from load encodings: 010 is SB, 000 is SW.
  function automatic logic [1:0] f_size(input logic wr, input logic [2:0] ctrl);
    logic [1:0] sz;
    if (wr) begin
      case (ctrl)
        3'b010:  sz = SZ_BYTE;
        3'b001:  sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (ctrl[1:0])
        2'b00:   sz = SZ_BYTE;
        2'b01:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic f_illegal(input logic wr, input logic [2:0] ctrl);
    if (wr)
      return !(ctrl == 3'b000 || ctrl == 3'b001 || ctrl == 3'b010);
    else
      return (ctrl == 3'b011 || ctrl == 3'b110 || ctrl == 3'b111);
  endfunction

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_size = f_size(DMWR, DMCtrl);
    w_ill  = f_illegal(DMWR, DMCtrl);
    w_mis  = 1'b0;
    if (!w_ill) begin
      if (w_size == SZ_HALF)
        w_mis = addr[0];
      else if (w_size == SZ_WORD)
        w_mis = (addr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_ill || w_mis)
            w_state_next = S_RESP;
          else if (DMWR && (w_size == SZ_WORD))
            w_state_next = S_WRITE;
          else
            w_state_next = S_READ;
        end
      end
      S_READ:    w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = r_wr ? S_WRITE : S_RESP;
      S_WRITE:   w_state_next = S_RESP;
      S_RESP:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // RAM strobes come straight from the state register so they cannot glitch.
  assign mem_en     = (r_state == S_READ) || (r_state == S_WRITE);
  assign mem_we     = (r_state == S_WRITE);
  assign mem_addr   = r_addr[ADDR_W+1:2];
  assign mem_wdata  = r_mem_wdata;
  assign resp_valid = (r_state == S_RESP);
  assign rdata      = r_rdata;
  assign misaligned = resp_valid && r_mis;
  assign illegal    = resp_valid && r_ill;

  assign w_size_q = f_size(r_wr, r_ctrl);

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (w_size_q)
      SZ_BYTE: w_load = r_ctrl[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: w_load = r_ctrl[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_merged = mem_rdata;
    if (w_size_q == SZ_BYTE) begin
      for (int i = 0; i < 4; i++) begin
        if (r_addr[1:0] == i[1:0])
          w_merged[8*i +: 8] = r_wdata[7:0];
      end
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata;
    end else begin
      w_merged[15:0] = r_wdata;
    end
  end

  // rdata is cleared on accept so stores and faults respond with zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr        <= 1'b0;
      r_ctrl      <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= 16'd0;
      r_mis       <= 1'b0;
      r_ill       <= 1'b0;
      r_rdata     <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_wr        <= DMWR;
        r_ctrl      <= DMCtrl;
        r_addr      <= addr[ADDR_W+1:0];
        r_wdata     <= wdata[15:0];
        r_mis       <= w_mis;
        r_ill       <= w_ill;
        r_rdata     <= 32'd0;
        r_mem_wdata <= wdata;
      end else if (r_state == S_CAPTURE) begin
        if (r_wr)
          r_mem_wdata <= w_merged;
        else
          r_rdata <= w_load;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit with a RAM model and a queue-based scoreboard.
module tb_data_mem_access_unit;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              DMWR;
  logic [2:0]        DMCtrl;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              resp_valid;
  logic [31:0]       rdata;
  logic              misaligned;
  logic              illegal;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0] ram [0:(1<<ADDR_W)-1];

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
    int          lat;
    int          rd;
    int          wr;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;

  data_mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .DMWR(DMWR), .DMCtrl(DMCtrl), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .misaligned(misaligned), .illegal(illegal),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per response pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_en && !mem_we) rd_cnt++;
      if (mem_en && mem_we)  wr_cnt++;
      if (resp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("misaligned", 32'(misaligned), 32'(e.mis));
          chk("illegal", 32'(illegal), 32'(e.ill));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
          chk("ram_reads", 32'(rd_cnt), 32'(e.rd));
          chk("ram_writes", 32'(wr_cnt), 32'(e.wr));
          $display("resp: rdata=%h mis=%0b ill=%0b lat=%0d rd=%0d wr=%0d",
                   rdata, misaligned, illegal, cyc - e.acc, rd_cnt, wr_cnt);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic txn(input logic wr, input logic [2:0] ctl, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] er, input logic em,
                     input logic ei, input int lat, input int rd, input int wn);
    exp_t e;
    int   n;
    @(negedge clk);
    wait_ready();
    DMWR = wr; DMCtrl = ctl; addr = a; wdata = wd; req_valid = 1'b1;
    e = '{er, em, ei, lat, rd, wn, cyc};
    q.push_back(e);
    @(negedge clk);
    // Garbage on the request bus while busy must be ignored.
    req_valid = 1'b0; DMWR = ~wr; DMCtrl = 3'b111; addr = 32'hFFFF_FFFF; wdata = 32'h1234_5678;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("resp_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'd0;
    ram[3] = 32'h8081_F2F3;
    ram[4] = 32'h1122_3344;
    ram[5] = 32'h5566_7788;
    rst = 1'b1; req_valid = 1'b0; DMWR = 1'b0; DMCtrl = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    //  wr   ctl     addr          wdata          exp rdata      mis   ill  lat rd wr
    txn(1'b0, 3'b000, 32'h0000_000C, 32'd0,        32'hFFFF_FFF3, 1'b0, 1'b0, 3, 1, 0); // LB
    txn(1'b0, 3'b100, 32'h0000_000E, 32'd0,        32'h0000_0081, 1'b0, 1'b0, 3, 1, 0); // LBU
    txn(1'b0, 3'b001, 32'h0000_000E, 32'd0,        32'hFFFF_8081, 1'b0, 1'b0, 3, 1, 0); // LH
    txn(1'b0, 3'b101, 32'h0000_000C, 32'd0,        32'h0000_F2F3, 1'b0, 1'b0, 3, 1, 0); // LHU
    txn(1'b0, 3'b010, 32'h0000_000C, 32'd0,        32'h8081_F2F3, 1'b0, 1'b0, 3, 1, 0); // LW
    txn(1'b0, 3'b000, 32'h0000_100F, 32'd0,        32'hFFFF_FF80, 1'b0, 1'b0, 3, 1, 0); // LB, wrapped addr
    txn(1'b1, 3'b010, 32'h0000_0011, 32'h0000_00AA, 32'd0,        1'b0, 1'b0, 4, 1, 1); // SB
    chk("ram4_after_sb", ram[4], 32'h1122_AA44);
    txn(1'b1, 3'b001, 32'h0000_0012, 32'h0000_BEEF, 32'd0,        1'b0, 1'b0, 4, 1, 1); // SH
    chk("ram4_after_sh", ram[4], 32'hBEEF_AA44);
    txn(1'b1, 3'b000, 32'h0000_0020, 32'hDEAD_BEEF, 32'd0,        1'b0, 1'b0, 2, 0, 1); // SW
    chk("ram8_after_sw", ram[8], 32'hDEAD_BEEF);
    txn(1'b0, 3'b010, 32'h0000_0022, 32'd0,        32'd0,         1'b1, 1'b0, 1, 0, 0); // LW misaligned
    txn(1'b0, 3'b111, 32'h0000_0022, 32'd0,        32'd0,         1'b0, 1'b1, 1, 0, 0); // illegal load
    txn(1'b1, 3'b001, 32'h0000_0013, 32'h0000_5555, 32'd0,        1'b1, 1'b0, 1, 0, 0); // SH misaligned
    txn(1'b1, 3'b011, 32'h0000_0010, 32'h0000_5555, 32'd0,        1'b0, 1'b1, 1, 0, 0); // illegal store
    chk("ram4_after_faults", ram[4], 32'hBEEF_AA44);

    // Reset while an SB sits in CAPTURE: no write, no response.
    @(negedge clk);
    wait_ready();
    DMWR = 1'b1; DMCtrl = 3'b010; addr = 32'h0000_0014; wdata = 32'h0000_0099; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("busy_before_rst", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_async_mem_en", 32'(mem_en), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_resp", 32'(resp_valid), 32'd0);
      chk("rst_no_mem_en", 32'(mem_en), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("ram5_untouched", ram[5], 32'h5566_7788);
    txn(1'b0, 3'b010, 32'h0000_0014, 32'd0,        32'h5566_7788, 1'b0, 1'b0, 3, 1, 0); // LW after reset

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_access_unit.md
Name: data_mem_access_unit

Overview:
- Consumes the data-memory controls (DMWR, DMCtrl) and ALU-computed address emitted by the instruction decoder; executes the load/store against a word-wide single-port synchronous RAM.
- RAM has no byte enables, so SB/SH run as a read-modify-write sequence.
- Sits between the execute stage and data RAM; returns sign/zero-extended load data for the register write-back mux.

Parameters:
ADDR_W, 10, word-address width of the data RAM (1024 words = 4 KiB).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit idle, request accepted when req_valid & req_ready
DMWR  in  1  1 = store, 0 = load
DMCtrl  in  3  access type (encodings below)
addr  in  32  byte address
wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle pulse: access complete
rdata  out  32  extended load result, valid with resp_valid
misaligned  out  1  valid with resp_valid: address not aligned to access size
illegal  out  1  valid with resp_valid: unsupported DMCtrl encoding
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM word address = addr[ADDR_W+1:2]
mem_wdata  out  32  RAM write word
mem_rdata  in  32  RAM read word, valid the cycle after mem_en & !mem_we

Behaviour:
- Encodings, loads (DMWR=0): 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011/110/111 illegal.
- Encodings, stores (DMWR=1): 010 SB, 001 SH, 000 SW; all others illegal.
- Reset (async, any state): state IDLE; resp_valid, misaligned, illegal, mem_en, mem_we = 0; rdata, mem_wdata, latched request = 0; mem_addr = 0. Reset mid-sequence aborts with no response and no RAM write after rst rises.
- States: IDLE, READ, CAPTURE, WRITE, RESP.
- req_ready = 1 only in IDLE. Acceptance latches DMWR, DMCtrl, addr, wdata. Inputs are ignored outside IDLE.
- From IDLE on accept:
  - illegal or misaligned -> RESP, with no RAM access.
  - load, SB, SH -> READ.
  - SW -> WRITE.
- Alignment rules: halfword requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned. illegal has priority; misaligned=0 when illegal=1.
- READ: mem_en=1, mem_we=0. Always -> CAPTURE.
- CAPTURE: sample mem_rdata.
  - Load: select byte addr[1:0] or halfword addr[1]; sign-extend (LB, LH) or zero-extend (LBU, LHU); register into rdata; -> RESP.
  - Store: merge wdata[7:0] into byte lane addr[1:0] (SB) or wdata[15:0] into halfword lane addr[1] (SH); register into mem_wdata; -> WRITE.
- WRITE: mem_en=1, mem_we=1. mem_wdata is either the merged word or wdata (SW). Always -> RESP.
- RESP: resp_valid=1 for exactly one cycle; misaligned/illegal reflect the request; rdata = 0 for stores and faults. -> IDLE.
- Latency in cycles from accept edge to resp_valid high: load 3, SW 2, SB/SH 4, fault 1. Back-to-back throughput: the next accept occurs in the cycle after RESP.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo 4·2^ADDR_W.
- mem_en/mem_we are decoded from the state register only; glitch-free, never high in IDLE or RESP.

Test Plan:
- After reset, preload RAM[3]=0x8081_F2F3; LB at addr 0x0C -> resp_valid 3 cycles after accept, rdata=0xFFFF_FFF3. LBU at 0x0E -> 0x0000_0081.
- LH at 0x0E on the same word -> rdata=0xFFFF_8081. LHU at 0x0C -> 0x0000_F2F3. LW at 0x0C -> 0x8081_F2F3.
- RAM[4]=0x1122_3344:
  - SB wdata=0xAA at 0x11 -> READ, CAPTURE, WRITE sequence; resp 4 cycles after accept; RAM[4]=0x1122_AA44.
  - Then SH wdata=0xBEEF at 0x12 -> RAM[4]=0xBEEF_AA44.
- SW 0xDEAD_BEEF at 0x20 -> single write cycle, resp 2 cycles after accept, RAM[8]=0xDEAD_BEEF; mem_en never asserted as a read.
- LW at 0x22 -> misaligned=1, illegal=0, resp 1 cycle after accept, no mem_en. Load DMCtrl=111 -> illegal=1, misaligned=0.
- Assert rst during CAPTURE of an SB -> no write reaches RAM, resp_valid stays 0, req_ready=1 after release; a following LW completes normally.
